// File: rtl/baudot_tx_multi.sv
// N-channel ITA2 transmitter: accept at edge T puts the start bit on tx from T+1, with automatic LTRS/FIGS insertion.
// din_ready is high only in IDLE; a char needing a shift holds the channel for two back-to-back frames.
module baudot_tx_multi #(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 50,
    parameter int CHANNELS   = 3,
    parameter int STOP_HALF  = 3,
    parameter int USOS       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6*CHANNELS-1:0] din,
    input  logic [CHANNELS-1:0]   din_valid,
    output logic [CHANNELS-1:0]   din_ready,
    output logic [CHANNELS-1:0]   tx,
    output logic [CHANNELS-1:0]   busy
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int STOP_CLKS    = STOP_HALF * CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT * 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [4:0] C_FIGS = 5'b11011;
    localparam logic [4:0] C_LTRS = 5'b11111;
    localparam logic [4:0] C_SP   = 5'b00100;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic [2:0]       r_bit;
        logic [4:0]       r_code;
        logic [4:0]       r_pend;
        logic             r_shift_pend;
        logic             r_figs;

        logic [5:0] w_din;
        logic       w_accept;
        logic       w_neutral;
        logic       w_insert;
        logic       w_bit_end;
        logic       w_stop_end;
        logic       w_figs_next;

        assign w_din      = din[6*c +: 6];
        assign w_accept   = din_valid[c] && din_ready[c];
        assign w_neutral  = (w_din[4:0] == 5'b00000) || (w_din[4:0] == 5'b00010) ||
                            (w_din[4:0] == 5'b01000) || (w_din[4:0] == C_SP)    ||
                            (w_din[4:0] == C_FIGS)   || (w_din[4:0] == C_LTRS);
        assign w_insert   = !w_neutral && (w_din[5] != r_figs);
        assign w_bit_end  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
        assign w_stop_end = (r_cnt == CNT_W'(STOP_CLKS - 1));

        // Shift state implied by the frame whose stop period is finishing
        always_comb begin
            w_figs_next = r_figs;
            if (r_code == C_FIGS)
                w_figs_next = 1'b1;
            else if (r_code == C_LTRS)
                w_figs_next = 1'b0;
            else if ((USOS != 0) && (r_code == C_SP))
                w_figs_next = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state      <= S_IDLE;
                r_cnt        <= '0;
                r_bit        <= '0;
                r_code       <= '0;
                r_pend       <= '0;
                r_shift_pend <= 1'b0;
                r_figs       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_pend  <= w_din[4:0];
                            r_state <= S_START;
                            if (w_insert) begin
                                r_code       <= w_din[5] ? C_FIGS : C_LTRS;
                                r_shift_pend <= 1'b1;
                            end else begin
                                r_code       <= w_din[4:0];
                                r_shift_pend <= 1'b0;
                            end
                        end
                    end
                    S_START: begin
                        if (w_bit_end) begin
                            r_cnt   <= '0;
                            r_bit   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            r_cnt <= '0;
                            if (r_bit == 3'd4)
                                r_state <= S_STOP;
                            else
                                r_bit <= r_bit + 3'd1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_stop_end) begin
                            r_cnt  <= '0;
                            r_figs <= w_figs_next;
                            // Deferred char follows its shift frame with no idle cycle
                            if (r_shift_pend) begin
                                r_code       <= r_pend;
                                r_shift_pend <= 1'b0;
                                r_bit        <= '0;
                                r_state      <= S_START;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

        assign din_ready[c] = (r_state == S_IDLE) && !reset;
        assign busy[c]      = (r_state != S_IDLE);
        assign tx[c]        = (r_state == S_START) ? 1'b0 :
                              (r_state == S_DATA)  ? r_code[r_bit] : 1'b1;
    end

endmodule

// File: tb/tb_baudot_tx_multi.sv
// Directed bench for baudot_tx_multi: three-channel USOS instance plus a one-channel USOS=0 instance.
module tb_baudot_tx_multi;

    logic       clk;
    logic       reset;
    logic [17:0] din;
    logic [2:0] din_valid;
    logic [2:0] din_ready;
    logic [2:0] tx;
    logic [2:0] busy;

    logic [5:0] nu_din;
    logic [0:0] nu_valid;
    logic [0:0] nu_rdy;
    logic [0:0] nu_tx;
    logic [0:0] nu_busy;

    int n_checks;
    int n_fail;

    logic [3:0] cap_tx   [0:319];
    logic [3:0] cap_busy [0:319];
    logic [3:0] cap_rdy  [0:319];

    baudot_tx_multi dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .busy(busy)
    );

    baudot_tx_multi #(.CHANNELS(1), .USOS(0)) dut_nu (
        .clk(clk), .reset(reset), .din(nu_din), .din_valid(nu_valid),
        .din_ready(nu_rdy), .tx(nu_tx), .busy(nu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference line waveform: bit k is tx in the k-th cycle after the accepting edge
    function automatic logic [149:0] exp_frame(input logic [4:0] code);
        logic [149:0] r;
        for (int k = 0; k < 150; k++) begin
            if (k < 20)       r[k] = 1'b0;
            else if (k < 120) r[k] = code[(k - 20) / 20];
            else              r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [149:0] wave(input int ch, input int off);
        logic [149:0] r;
        for (int i = 0; i < 150; i++) r[i] = cap_tx[off + i][ch];
        return r;
    endfunction

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_tx[i]   = {nu_tx, tx};
            cap_busy[i] = {nu_busy, busy};
            cap_rdy[i]  = {nu_rdy, din_ready};
        end
    endtask

    // Channel 3 addresses the USOS=0 instance
    task automatic send(input int ch, input logic [5:0] d);
        if (ch == 3) begin
            nu_din   = d;
            nu_valid = 1'b1;
        end else begin
            din[6*ch +: 6] = d;
            din_valid[ch]  = 1'b1;
        end
        @(posedge clk);
        #1;
        nu_valid  = 1'b0;
        din_valid = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({nu_tx, tx} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_tx: got %b expected 1111", {nu_tx, tx});
        end
        n_checks++;
        if ({nu_busy, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0000", {nu_busy, busy});
        end
        n_checks++;
        if ({nu_rdy, din_ready} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready_low: got %b expected 0000", {nu_rdy, din_ready});
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({nu_rdy, din_ready} !== 4'b1111) begin
            n_fail++; $display("FAIL reset_ready_after: got %b expected 1111", {nu_rdy, din_ready});
        end
    endtask

    task automatic test_frame_a();
        logic [149:0] got, expv;
        int bad;
        send(0, 6'b0_00011);
        capture(160);
        got = wave(0, 0); expv = exp_frame(5'b00011);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL frame_A: got %h expected %h", got, expv);
        end
        n_checks++;
        if (cap_rdy[149][0] !== 1'b0 || cap_rdy[150][0] !== 1'b1) begin
            n_fail++; $display("FAIL ready_A: got %b%b expected 01", cap_rdy[149][0], cap_rdy[150][0]);
        end
        bad = 0;
        for (int i = 0; i < 160; i++) if (cap_tx[i][2:1] !== 2'b11) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL idle_ch12: got %0d non-mark cycles expected 0", bad);
        end
    endtask

    task automatic test_shift_insert();
        logic [149:0] got, expv;
        send(0, 6'b1_00001);
        capture(310);
        got = wave(0, 0); expv = exp_frame(5'b11011);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL ins_figs_frame: got %h expected %h", got, expv);
        end
        got = wave(0, 150); expv = exp_frame(5'b00001);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL ins_char_frame: got %h expected %h", got, expv);
        end
        n_checks++;
        if (cap_busy[299][0] !== 1'b1 || cap_busy[300][0] !== 1'b0 || cap_rdy[300][0] !== 1'b1) begin
            n_fail++; $display("FAIL ins_busy_300: got %b%b%b expected 101",
                               cap_busy[299][0], cap_busy[300][0], cap_rdy[300][0]);
        end
        send(0, 6'b1_00001);
        capture(160);
        got = wave(0, 0); expv = exp_frame(5'b00001);
        n_checks++;
        if (got !== expv || cap_busy[150][0] !== 1'b0) begin
            n_fail++; $display("FAIL figs_no_ins: got %h busy150=%b expected %h busy150=0",
                               got, cap_busy[150][0], expv);
        end
    endtask

    task automatic test_usos();
        logic [149:0] got, expv;
        send(0, 6'b1_00100);
        capture(160);
        got = wave(0, 0); expv = exp_frame(5'b00100);
        n_checks++;
        if (got !== expv || cap_busy[150][0] !== 1'b0) begin
            n_fail++; $display("FAIL usos_sp: got %h busy150=%b expected %h busy150=0",
                               got, cap_busy[150][0], expv);
        end
        send(0, 6'b1_00001);
        capture(310);
        got = wave(0, 0); expv = exp_frame(5'b11011);
        n_checks++;
        if (got !== expv || cap_busy[299][0] !== 1'b1) begin
            n_fail++; $display("FAIL usos_reinsert: got %h busy299=%b expected %h busy299=1",
                               got, cap_busy[299][0], expv);
        end
        // USOS=0 instance: enter FIGS, send SP, then a figs char must not re-insert
        send(3, 6'b1_00001);
        capture(310);
        got = wave(3, 150); expv = exp_frame(5'b00001);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL nousos_first: got %h expected %h", got, expv);
        end
        send(3, 6'b1_00100);
        capture(160);
        send(3, 6'b1_00001);
        capture(160);
        got = wave(3, 0); expv = exp_frame(5'b00001);
        n_checks++;
        if (got !== expv || cap_busy[150][3] !== 1'b0) begin
            n_fail++; $display("FAIL nousos_no_reinsert: got %h busy150=%b expected %h busy150=0",
                               got, cap_busy[150][3], expv);
        end
    endtask

    task automatic test_multi_channel();
        logic [149:0] got, expv;
        din       = {6'b1_00111, 6'b0_10000, 6'b1_00011};
        din_valid = 3'b111;
        @(posedge clk);
        #1;
        din_valid = '0;
        capture(310);
        got = wave(0, 0); expv = exp_frame(5'b00011);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL multi_ch0: got %h expected %h", got, expv);
        end
        got = wave(1, 0); expv = exp_frame(5'b10000);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL multi_ch1: got %h expected %h", got, expv);
        end
        got = wave(2, 0); expv = exp_frame(5'b11011);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL multi_ch2_shift: got %h expected %h", got, expv);
        end
        got = wave(2, 150); expv = exp_frame(5'b00111);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL multi_ch2_char: got %h expected %h", got, expv);
        end
        n_checks++;
        if (cap_busy[149][2:0] !== 3'b111 || cap_busy[150][2:0] !== 3'b100 ||
            cap_busy[299][2:0] !== 3'b100 || cap_busy[300][2:0] !== 3'b000) begin
            n_fail++; $display("FAIL multi_busy: got %b %b %b %b expected 111 100 100 000",
                               cap_busy[149][2:0], cap_busy[150][2:0],
                               cap_busy[299][2:0], cap_busy[300][2:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [149:0] got, expv;
        send(0, 6'b1_00011);
        capture(50);
        got = wave(0, 0); expv = exp_frame(5'b00011);
        n_checks++;
        if (got[49:0] !== expv[49:0]) begin
            n_fail++; $display("FAIL mid_prefix: got %h expected %h", got[49:0], expv[49:0]);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (din_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_ready_in_reset: got %b expected 0", din_ready[0]);
        end
        @(negedge clk);
        n_checks++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_abort: got tx=%b busy=%b expected tx=1 busy=0", tx[0], busy[0]);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (din_ready[0] !== 1'b1) begin
            n_fail++; $display("FAIL mid_ready_release: got %b expected 1", din_ready[0]);
        end
        send(0, 6'b1_00001);
        capture(310);
        got = wave(0, 0); expv = exp_frame(5'b11011);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL mid_ltrs_restored: got %h expected %h", got, expv);
        end
        got = wave(0, 150); expv = exp_frame(5'b00001);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL mid_char_after: got %h expected %h", got, expv);
        end
    endtask

    task automatic test_back_to_back();
        logic [149:0] got, expv;
        din[5:0]     = 6'b1_00101;
        din_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        din[5:0] = 6'b1_00110;
        fork
            capture(310);
            begin
                repeat (151) @(posedge clk);
                #1;
                din_valid[0] = 1'b0;
            end
        join
        got = wave(0, 0); expv = exp_frame(5'b00101);
        n_checks++;
        if (got !== expv) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h", got, expv);
        end
        got = wave(0, 151); expv = exp_frame(5'b00110);
        n_checks++;
        if (got !== expv || cap_tx[150][0] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second: got %h gap=%b expected %h gap=1",
                               got, cap_tx[150][0], expv);
        end
        n_checks++;
        if (cap_rdy[150][0] !== 1'b1 || cap_rdy[151][0] !== 1'b0 || cap_busy[301][0] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_handshake: got %b%b%b expected 100",
                               cap_rdy[150][0], cap_rdy[151][0], cap_busy[301][0]);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        din       = '0;
        din_valid = '0;
        nu_din    = '0;
        nu_valid  = '0;
        test_reset();
        test_frame_a();
        test_shift_insert();
        test_usos();
        test_multi_channel();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
